pwm_timer: RTL and testbench

Memory-mapped PWM timer peripheral on the SoC data bus, downstream of the CPU load/store path and in parallel with dmem/gpio. It produces the SoC top-level pwm_out pin.
- CPU programs period, duty, prescale and polarity through word-aligned register writes.
- Period and duty are double-buffered, so mid-period writes never glitch the output.

---
 rtl/soc_pkg.sv | 28 ++
 rtl/pwm_prescaler.sv | 40 ++++
 rtl/pwm_timer.sv | 199 +++++++++++++++++++
 tb/tb_pwm_timer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// ---------------------------------------------------------------------------
// soc_pkg: shared SoC constants for the PWM timer peripheral.
//   - Register byte offsets on the data bus (5-bit offset space).
//   - CTRL register bit positions.
//   - reg_offset(): folds a byte address onto its word-aligned register offset.
// Optional feature macro used by consumers: PWM_IRQ_EN.
// ---------------------------------------------------------------------------
package soc_pkg;

    // Register byte offsets
    localparam logic [4:0] PWM_CTRL   = 5'h00;
    localparam logic [4:0] PWM_PERIOD = 5'h04;
    localparam logic [4:0] PWM_DUTY   = 5'h08;
    localparam logic [4:0] PWM_COUNT  = 5'h0C;
    localparam logic [4:0] PWM_STATUS = 5'h10;

    // CTRL bit indices
    localparam int EN        = 0;
    localparam int INV       = 1;
    localparam int IE        = 2;
    localparam int PRESC_LSB = 8;

    // Byte lanes are not decoded: the two low address bits are dropped.
    function automatic logic [4:0] reg_offset(input logic [4:0] addr);
        return {addr[4:2], 2'b00};
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// ---------------------------------------------------------------------------
// pwm_prescaler: clock divider for the PWM counter.
//   presc_cnt counts 0..presc and wraps while en=1; held at 0 while en=0.
//   tick is high on the cycle where presc_cnt equals presc (every cycle
//   when presc=0).
// Ports:
//   clk    system clock
//   rst    asynchronous active-low reset
//   en     counter enable (CTRL.EN)
//   presc  prescaler compare value (CTRL.PRESC)
//   tick   one-cycle count strobe for the PWM counter
// ---------------------------------------------------------------------------
module pwm_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               at_top;

    assign at_top = (presc_cnt == presc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt <= '0;
        end else if (!en || at_top) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    assign tick = en & at_top;

endmodule

// File: rtl/pwm_timer.sv
// ---------------------------------------------------------------------------
// pwm_timer: memory-mapped PWM timer with double-buffered period/duty.
//   Registers (byte offsets): 0x00 CTRL {PRESC[15:8], IE[2], INV[1], EN[0]},
//   0x04 PERIOD shadow, 0x08 DUTY shadow, 0x0C COUNT (RO), 0x10 STATUS.
//   Shadow values move to the active registers on each wrap tick and on
//   every cycle while EN=0, so a running period is never cut short.
// Optional feature: define PWM_IRQ_EN to get the sticky STATUS.WRAP flag
//   (W1C), CTRL.IE and the irq output. Without it, STATUS and CTRL.IE read 0.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   sel      peripheral select from the SoC address decoder
//   we       write strobe (qualified by sel)
//   addr     byte offset, bits [1:0] ignored
//   wdata    write data
//   rdata    combinational read data, 0 when sel=0
//   pwm_out  registered PWM waveform
//   irq      WRAP & IE (PWM_IRQ_EN only)
// ---------------------------------------------------------------------------
module pwm_timer
    import soc_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        pwm_out
`ifdef PWM_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic [4:0]         offset;
    logic               wr;
    logic               wr_ctrl;
    logic               wr_period;
    logic               wr_duty;

    logic               ctrl_en;
    logic               ctrl_inv;
    logic [PRESC_W-1:0] ctrl_presc;
    logic [CNT_W-1:0]   period_sh;
    logic [CNT_W-1:0]   duty_sh;
    logic [CNT_W-1:0]   period_act;
    logic [CNT_W-1:0]   duty_act;
    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic               wrap;
    logic               raw;

    // Only a subset of wdata bits lands in registers.
    logic               unused_wdata;
    assign unused_wdata = ^wdata;

    assign offset    = reg_offset(addr);
    assign wr        = sel & we;
    assign wr_ctrl   = wr && (offset == PWM_CTRL);
    assign wr_period = wr && (offset == PWM_PERIOD);
    assign wr_duty   = wr && (offset == PWM_DUTY);

    // ---------------- register file ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_en    <= 1'b0;
            ctrl_inv   <= 1'b0;
            ctrl_presc <= '0;
        end else if (wr_ctrl) begin
            ctrl_en    <= wdata[EN];
            ctrl_inv   <= wdata[INV];
            ctrl_presc <= wdata[PRESC_LSB +: PRESC_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_sh <= '0;
            duty_sh   <= '0;
        end else begin
            if (wr_period) period_sh <= wdata[CNT_W-1:0];
            if (wr_duty)   duty_sh   <= wdata[CNT_W-1:0];
        end
    end

    // ---------------- prescaler ----------------
    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl_en),
        .presc (ctrl_presc),
        .tick  (tick)
    );

    // ---------------- counter ----------------
    // cnt never exceeds period_act: period_act only changes at a wrap
    // (cnt returns to 0) or while disabled (cnt held at 0).
    assign wrap = tick & (cnt == period_act);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!ctrl_en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    // ---------------- shadow load ----------------
    // A shadow write on the wrap edge is captured into the shadow, while the
    // active register takes the pre-write shadow value (plain NBA ordering).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_act <= '0;
            duty_act   <= '0;
        end else if (!ctrl_en || wrap) begin
            period_act <= period_sh;
            duty_act   <= duty_sh;
        end
    end

    // ---------------- output ----------------
    // duty_act > period_act leaves raw high for the whole period; duty_act=0
    // keeps it low. Disabled output parks at the INV level.
    assign raw = (cnt < duty_act);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= ctrl_en ? (raw ^ ctrl_inv) : ctrl_inv;
        end
    end

`ifdef PWM_IRQ_EN
    // ---------------- wrap interrupt ----------------
    logic ctrl_ie;
    logic wrap_flag;
    logic clr_wrap;

    assign clr_wrap = wr && (offset == PWM_STATUS) && wdata[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_ie <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_ie <= wdata[IE];
        end
    end

    // Set has priority over a same-cycle W1C so no wrap is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_flag <= 1'b0;
        end else if (wrap) begin
            wrap_flag <= 1'b1;
        end else if (clr_wrap) begin
            wrap_flag <= 1'b0;
        end
    end

    assign irq = wrap_flag & ctrl_ie;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (offset)
                PWM_CTRL: begin
                    rdata[EN]                    = ctrl_en;
                    rdata[INV]                   = ctrl_inv;
`ifdef PWM_IRQ_EN
                    rdata[IE]                    = ctrl_ie;
`endif
                    rdata[PRESC_LSB +: PRESC_W]  = ctrl_presc;
                end
                PWM_PERIOD: rdata[CNT_W-1:0] = period_sh;
                PWM_DUTY:   rdata[CNT_W-1:0] = duty_sh;
                PWM_COUNT:  rdata[CNT_W-1:0] = cnt;
                PWM_STATUS: begin
`ifdef PWM_IRQ_EN
                    rdata[0] = wrap_flag;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_timer.sv
// ---------------------------------------------------------------------------
// tb_pwm_timer: self-checking bench for pwm_timer.
//   Reference model: counter value derived arithmetically from the number of
//   enabled cycles k since enable: cnt = (k / (PRESC+1)) mod (PERIOD+1), wrap
//   when (k+1) is a multiple of (PRESC+1)*(PERIOD+1). Duty changes are applied
//   at the modelled wraps. PERIOD/PRESC are only changed while disabled.
// ---------------------------------------------------------------------------
module tb_pwm_timer;
    import soc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        we  = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        pwm_out;
`ifdef PWM_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int m_en, m_inv, m_ie, m_presc;
    int m_per_sh, m_duty_sh, m_per, m_duty;
    int m_k, m_cnt, m_pwm, m_flag;

    pwm_timer #(.CNT_W(16), .PRESC_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .pwm_out (pwm_out)
`ifdef PWM_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_inv = 0; m_ie = 0; m_presc = 0;
        m_per_sh = 0; m_duty_sh = 0; m_per = 0; m_duty = 0;
        m_k = 0; m_cnt = 0; m_pwm = 0; m_flag = 0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [4:0] o;
        o = {a[4:2], 2'b00};
        case (o)
            PWM_CTRL: begin
`ifdef PWM_IRQ_EN
                return 32'((m_presc << 8) | (m_ie << 2) | (m_inv << 1) | m_en);
`else
                return 32'((m_presc << 8) | (m_inv << 1) | m_en);
`endif
            end
            PWM_PERIOD: return 32'(m_per_sh);
            PWM_DUTY:   return 32'(m_duty_sh);
            PWM_COUNT:  return 32'(m_cnt);
`ifdef PWM_IRQ_EN
            PWM_STATUS: return 32'(m_flag);
`endif
            default:    return 32'd0;
        endcase
    endfunction

    // One bus cycle: drive at negedge, check read data before the edge,
    // advance the model at the edge, check outputs at the next negedge.
    task automatic step(input logic s, input logic w, input logic [4:0] a, input logic [31:0] d);
        int  cyc;
        bit  wrap_now;
        logic [4:0] o;
        sel = s; we = w; addr = a; wdata = d;
        #1;
        if (s) chk("rdata", rdata, exp_read(a));
        else   chk("rdata_nosel", rdata, 32'd0);
        @(posedge clk);
        cyc      = (m_presc + 1) * (m_per + 1);
        wrap_now = (m_en != 0) && (((m_k + 1) % cyc) == 0);
        m_pwm    = (m_en != 0) ? (int'(m_cnt < m_duty) ^ m_inv) : m_inv;
        if (m_en != 0) begin
            m_k++;
            m_cnt = (m_k / (m_presc + 1)) % (m_per + 1);
        end else begin
            m_k = 0;
            m_cnt = 0;
        end
        if (wrap_now || m_en == 0) begin
            m_per  = m_per_sh;
            m_duty = m_duty_sh;
        end
        o = {a[4:2], 2'b00};
`ifdef PWM_IRQ_EN
        if (wrap_now) m_flag = 1;
        else if (s && w && o == PWM_STATUS && d[0]) m_flag = 0;
`endif
        if (s && w) begin
            case (o)
                PWM_CTRL: begin
                    m_en    = int'(d[0]);
                    m_inv   = int'(d[1]);
`ifdef PWM_IRQ_EN
                    m_ie    = int'(d[2]);
`endif
                    m_presc = int'(d[15:8]);
                end
                PWM_PERIOD: m_per_sh  = int'(d[15:0]);
                PWM_DUTY:   m_duty_sh = int'(d[15:0]);
                default: ;
            endcase
        end
        @(negedge clk);
        chk("pwm_out", pwm_out, m_pwm);
`ifdef PWM_IRQ_EN
        chk("irq", irq, 32'(m_flag & m_ie));
`endif
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d);
    endtask

    // Idle cycles reading COUNT; returns number of cycles pwm_out was high.
    task automatic idle(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, PWM_COUNT, 32'd0);
            if (pwm_out === 1'b1) hi++;
        end
    endtask

    task automatic run_to_cnt(input int c);
        int g;
        g = 0;
        while (m_cnt != c && g < 64) begin
            step(1'b1, 1'b0, PWM_COUNT, 32'd0);
            g++;
        end
        chk("reach_cnt", rdata, 32'(c));
    endtask

    task automatic config_run(input int per, input int duty, input int presc, input int inv);
        wr(PWM_CTRL, 32'd0);
        wr(PWM_PERIOD, 32'(per));
        wr(PWM_DUTY, 32'(duty));
        wr(PWM_CTRL, 32'((presc << 8) | (inv << 1) | 1));
    endtask

    initial begin
        int hi;
        logic [4:0] ra;
        model_reset();

        // ---- reset state ----
        #1;
        chk("rst_pwm", pwm_out, 32'd0);
        chk("rst_nosel", rdata, 32'd0);
        for (int i = 0; i < 8; i++) begin
            sel = 1'b1; addr = 5'(i * 4);
            #1;
            chk("rst_reg", rdata, 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_pwm", pwm_out, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 5'(i * 4), 32'd0);
        step(1'b0, 1'b0, PWM_COUNT, 32'd0);

        // ---- PERIOD=9 DUTY=3 PRESC=0 ----
        config_run(9, 3, 0, 0);
        idle(10, hi);
        idle(20, hi);
        chk("hi_p9_d3", 32'(hi), 32'd6);

        // ---- PRESC=1, then INV ----
        config_run(9, 3, 1, 0);
        idle(20, hi);
        idle(20, hi);
        chk("hi_presc1", 32'(hi), 32'd6);
        wr(PWM_CTRL, 32'((1 << 8) | 2 | 1));
        idle(20, hi);
        chk("hi_presc1_inv", 32'(hi), 32'd14);

        // ---- mid-period duty change, 100 %, 0 % ----
        config_run(9, 3, 0, 0);
        run_to_cnt(5);
        wr(PWM_DUTY, 32'd7);
        idle(30, hi);
        idle(10, hi);
        chk("hi_d7", 32'(hi), 32'd7);
        wr(PWM_DUTY, 32'd15);
        idle(12, hi);
        idle(10, hi);
        chk("hi_d15", 32'(hi), 32'd10);
        wr(PWM_DUTY, 32'd0);
        idle(12, hi);
        idle(10, hi);
        chk("hi_d0", 32'(hi), 32'd0);

        // ---- period 0 ----
        config_run(0, 1, 0, 0);
        idle(8, hi);
        config_run(0, 0, 0, 1);
        idle(8, hi);

        // ---- disable mid-period and re-enable ----
        config_run(9, 3, 0, 0);
        run_to_cnt(6);
        wr(PWM_CTRL, 32'd0);
        idle(3, hi);
        chk("dis_cnt", rdata, 32'd0);
        wr(PWM_CTRL, 32'd1);
        idle(15, hi);

`ifdef PWM_IRQ_EN
        // ---- wrap interrupt ----
        wr(PWM_CTRL, 32'd0);
        wr(PWM_STATUS, 32'd1);
        wr(PWM_PERIOD, 32'd4);
        wr(PWM_DUTY, 32'd2);
        wr(PWM_CTRL, 32'(4 | 1));
        idle(4, hi);
        chk("irq_before", irq, 32'd0);
        idle(1, hi);
        chk("irq_cycle5", irq, 32'd1);
        wr(PWM_STATUS, 32'd1);
        chk("irq_w1c", irq, 32'd0);
        run_to_cnt(4);
        wr(PWM_STATUS, 32'd1);
        chk("irq_set_wins", irq, 32'd1);
`endif

        // ---- randomized configurations ----
        for (int t = 0; t < 10; t++) begin
            int per, duty, presc, inv, ie;
            per   = int'($urandom_range(0, 12));
            duty  = int'($urandom_range(0, per + 2));
            presc = int'($urandom_range(0, 3));
            inv   = int'($urandom_range(0, 1));
            ie    = int'($urandom_range(0, 1));
            wr(PWM_CTRL, 32'd0);
            wr(5'(5'h14 + 5'($urandom_range(0, 2) * 4)), $urandom);
            wr(PWM_PERIOD, 32'(per));
            wr(PWM_DUTY, 32'(duty));
            wr(PWM_CTRL, 32'((presc << 8) | (ie << 2) | (inv << 1) | 1));
            for (int c = 0; c < 50; c++) begin
                int r;
                r = int'($urandom_range(0, 15));
                if (r == 0) begin
                    wr(PWM_DUTY, 32'($urandom_range(0, per + 2)));
                end else if (r == 1) begin
                    wr(PWM_STATUS, 32'($urandom_range(0, 1)));
                end else begin
                    ra = 5'($urandom_range(0, 31));
                    step(1'b1, 1'b0, ra, 32'd0);
                end
            end
        end

        // ---- asynchronous reset mid-period ----
        config_run(3, 9, 0, 0);
        idle(6, hi);
        chk("pre_rst_high", pwm_out, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_pwm", pwm_out, 32'd0);
        chk("async_rst_cnt", rdata, 32'd0);
        addr = PWM_CTRL;
        #1;
        chk("async_rst_ctrl", rdata, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(5, hi);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
